systolic_feeder: RTL
====================

# systolic_feeder

Input staging stage placed directly upstream of the K×K systolic array. Buffers incoming activation vectors and one weight matrix, then presents activations to the array's row inputs with the diagonal skew the array needs: lane i is delayed i cycles. It also generates the array's one-cycle weight-load strobe. Both inputs use valid/ready handshakes so a DMA or host port can feed it without knowing the array timing.

## Interface
Parameters:
- `K`, 2: array dimension; lanes = K.
- `DW`, 8: element width in bits.
- `DEPTH`, 4: activation FIFO depth in vectors; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all logic on posedge.
- `rst`  in  1  reset. Synchronous, active-high.
- `in_valid`  in  1  activation vector offered.
- `in_ready`  out  1  FIFO can accept; equals `!full`.
- `in_data`  in  [K-1:0][DW-1:0]  activation vector; lane i feeds array row i.
- `w_valid`  in  1  weight matrix offered.
- `w_ready`  out  1  high only in IDLE.
- `w_data`  in  [K-1:0][K-1:0][DW-1:0]  weight matrix.
- `load_weights`  out  1  one-cycle strobe to the array.
- `weights_out`  out  [K-1:0][K-1:0][DW-1:0]  latched weights; held stable between loads.
- `arr_data`  out  [K-1:0][DW-1:0]  skewed activations to the array.
- `arr_valid`  out  [K-1:0]  per-lane valid, skewed together with `arr_data`.
- `busy`  out  1  high in WLOAD, STREAM and DRAIN.
- `level`  out  $clog2(DEPTH+1)  FIFO occupancy.

## Operation
- FIFO: push on `in_valid && in_ready`. Pop only as driven by the FSM. Push and pop in the same cycle is legal whenever not full; `level` stays unchanged in that case. There is no bypass: a vector pushed into an empty FIFO is not popped on the same edge.
- `wl_done` flag: set on WLOAD entry, cleared only by `rst`.
- FSM states:
  - IDLE:
    - if `w_valid`: latch `w_data` into `weights_out`; go to WLOAD. Weights have priority over streaming.
    - else if `level != 0 && wl_done`: pop; go to STREAM.
  - WLOAD: `load_weights` = 1 for this single cycle; go to IDLE.
  - STREAM:
    - pop every edge while `level != 0`.
    - if `level == 0` at the edge: go to DRAIN with drain counter = K-1.
  - DRAIN:
    - no pops; decrement the counter; at 0 go to IDLE.
    - if K==1, DRAIN lasts 0 cycles: STREAM goes straight to IDLE.
    - a vector arriving during DRAIN waits for IDLE.
- Skew: stage 0 registers the popped vector and its valid. Lane i output = stage-0 lane i delayed by i further registers. Lane 0 has zero extra delay.
- Non-popping edges shift a 0 valid into stage 0.
- `w_data` accepted in IDLE only. A weight change therefore never overlaps activations still in flight through the skew.

## Timing
- Reset values: `in_ready`=1, `w_ready`=1, `load_weights`=0, `weights_out`=0, `arr_data`=0, `arr_valid`=0, `busy`=0, `level`=0.
- Reset state: FSM in IDLE, `wl_done`=0, skew registers cleared.
- Reset asserted mid-operation: the same values are reached at the next edge, and in-flight data is discarded.
- Weight latency:
  - `w_valid && w_ready` at edge t → `load_weights`=1 during cycle t..t+1, with `weights_out` already valid.
  - `w_ready`=0 from t until IDLE is re-entered.
- Activation latency: pop at edge p → `arr_valid[i]`=1 and `arr_data[i]` valid during the cycle after edge p+i.
- First-vector latency from IDLE: push at edge t → pop at t+1 → lane i valid after edge t+1+i.
- Throughput: one vector per cycle while streaming.
- Full FIFO: `in_ready`=0. A push attempted while full is ignored and `level` does not change.
- Empty in STREAM: go to DRAIN as above; no underflow pop.

## Configuration
- `FEEDER_ZERO_PAD_EN`
  - Defined: `arr_data[i]` is forced to 0 whenever `arr_valid[i]`=0. This keeps the array's accumulators clean during ramp-up and drain.
  - Undefined: `arr_data[i]` shows the raw skew register contents, so stale data may appear while invalid. Saves K×DW AND gates.
- `arr_valid` behaviour is identical in both builds.

## Test plan
All cases use K=2, DW=8, DEPTH=4.
- Reset then idle: all outputs at their reset values; `in_ready`=1, `w_ready`=1.
- Weight load, `w_data`={{4,3},{2,1}}: `load_weights` is high for exactly 1 cycle, `weights_out` holds that value, `w_ready` is low for 1 cycle.
- After a weight load, push {0x11,0x22} at edge t: `arr_data[0]`=0x11 after t+1, `arr_data[1]`=0x22 after t+2, each lane valid exactly 1 cycle, `busy` falls after DRAIN.
- Push 5 vectors back-to-back with no weights loaded: `level` reaches 4, `in_ready`=0, the 5th push is ignored, and nothing streams until a weight load.
- Reset asserted mid-STREAM with level=2: after the next edge, `level`=0, `arr_valid`=0, `busy`=0. With `FEEDER_ZERO_PAD_EN` defined, `arr_data`=0 on every invalid cycle across all tests.
- `w_valid` and a pending vector together in IDLE: weights win, the vector is popped the cycle after WLOAD.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Handshake and array-side bundle for systolic_feeder.
// Both input channels transfer on a cycle where valid && ready are high at posedge clk;
// the source holds valid/data stable until that edge, and ready never depends on valid.
interface systolic_feeder_if #(
    parameter int K     = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    logic                          in_valid;
    logic                          in_ready;
    logic [K-1:0][DW-1:0]          in_data;
    logic                          w_valid;
    logic                          w_ready;
    logic [K-1:0][K-1:0][DW-1:0]   w_data;
    logic                          load_weights;
    logic [K-1:0][K-1:0][DW-1:0]   weights_out;
    logic [K-1:0][DW-1:0]          arr_data;
    logic [K-1:0]                  arr_valid;
    logic                          busy;
    logic [$clog2(DEPTH+1)-1:0]    level;
    logic [1:0]                    dbg_state;

    modport master (
        output in_valid, in_data, w_valid, w_data,
        input  in_ready, w_ready, load_weights, weights_out,
        input  arr_data, arr_valid, busy, level, dbg_state
    );

    modport slave (
        input  in_valid, in_data, w_valid, w_data,
        output in_ready, w_ready, load_weights, weights_out,
        output arr_data, arr_valid, busy, level, dbg_state
    );
endinterface

// File: rtl/systolic_feeder.sv
// Activation FIFO + weight latch feeding a KxK systolic array with per-lane diagonal skew.
// Optional FEEDER_ZERO_PAD_EN: force arr_data lanes to zero while their valid is low.
module systolic_feeder #(
    parameter int K     = 2,
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    systolic_feeder_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef logic [K-1:0][DW-1:0] vec_t;
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WLOAD  = 2'd1,
        S_STREAM = 2'd2,
        S_DRAIN  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   drain_cnt, drain_cnt_nxt;
    logic            wl_done;
    logic            pop;
    logic            push;
    logic            w_take;

    // ---------------- activation FIFO ----------------
    vec_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   count;
    logic            full, empty;
    vec_t            head;

    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.in_valid && !full;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.in_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            drain_cnt <= drain_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pop           = 1'b0;
        w_take        = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.w_valid) begin
                    w_take    = 1'b1;
                    state_nxt = S_WLOAD;
                end else if (!empty && wl_done) begin
                    pop       = 1'b1;
                    state_nxt = S_STREAM;
                end
            end
            S_WLOAD: state_nxt = S_IDLE;
            S_STREAM: begin
                if (!empty) begin
                    pop = 1'b1;
                end else if (K == 1) begin
                    state_nxt = S_IDLE;
                end else begin
                    state_nxt     = S_DRAIN;
                    drain_cnt_nxt = CW'(K - 1);
                end
            end
            S_DRAIN: begin
                drain_cnt_nxt = drain_cnt - CW'(1);
                if (drain_cnt_nxt == '0) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Weights are only sampled in IDLE, so nothing in the skew can see a weight change.
    always_ff @(posedge clk) begin
        if (rst) begin
            wl_done         <= 1'b0;
            bus.weights_out <= '0;
        end else if (w_take) begin
            wl_done         <= 1'b1;
            bus.weights_out <= bus.w_data;
        end
    end

    // ---------------- diagonal skew ----------------
    logic [K-1:0] lane_v;
    vec_t         lane_d;

    for (genvar i = 0; i < K; i++) begin : g_lane
        logic [i:0]    v_pipe;
        logic [DW-1:0] d_pipe [i+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                v_pipe <= '0;
                for (int j = 0; j <= i; j++) d_pipe[j] <= '0;
            end else begin
                v_pipe[0] <= pop;
                if (pop) d_pipe[0] <= head[i];
                for (int j = 1; j <= i; j++) begin
                    v_pipe[j] <= v_pipe[j-1];
                    d_pipe[j] <= d_pipe[j-1];
                end
            end
        end

        assign lane_v[i] = v_pipe[i];
        assign lane_d[i] = d_pipe[i];
    end

    vec_t arr_data_q;
`ifdef FEEDER_ZERO_PAD_EN
    always_comb begin
        arr_data_q = '0;
        for (int i = 0; i < K; i++) begin
            if (lane_v[i]) arr_data_q[i] = lane_d[i];
        end
    end
`else
    assign arr_data_q = lane_d;
`endif

    // ---------------- outputs ----------------
    assign bus.in_ready     = !full;
    assign bus.w_ready      = (state == S_IDLE);
    assign bus.load_weights = (state == S_WLOAD);
    assign bus.busy         = (state != S_IDLE);
    assign bus.level        = count;
    assign bus.arr_valid    = lane_v;
    assign bus.arr_data     = arr_data_q;
    assign bus.dbg_state    = state;

    a_no_underflow: assert property (@(posedge clk) disable iff (rst) pop |-> !empty);
    a_level_bound:  assert property (@(posedge clk) disable iff (rst) count <= LW'(DEPTH));

endmodule
